mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single main-memory port between the instruction-side refill requester (I) and the data-side cache management unit (D). It sequences fixed-length line bursts: one word address per memory handshake, per-word acks and a done pulse back to the winning requester. It sits between the two cache controllers and main memory. Its `mem_busy` output feeds stall generation in the hazard unit.

## Interface
- `WORDS`, 4: words per line burst; power of two, at least 2.
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width; a word is 4 bytes.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `i_req`  in  1  I requests a line read; held until `i_done`.
- `i_addr`  in  ADDR_W  I line address, stable while `i_req`; low bits are ignored.
- `i_ack`  out  1  I word valid on `i_rdata` this cycle.
- `i_rdata`  out  DATA_W  read word.
- `i_done`  out  1  last word of the I burst.
- `d_req`, `d_we`, `d_addr`  in  1/1/ADDR_W  D request, write flag (dirty writeback) and line address; all held until `d_done`.
- `d_wdata`  in  DATA_W  write word for the current `word_idx`, supplied combinationally by D.
- `d_ack`, `d_rdata`, `d_done`  out  1/DATA_W/1  same meaning as the I-side signals.
- `word_idx`  out  log2(WORDS)  index of the word currently in flight.
- `mem_cs`, `mem_we`  out  1/1  memory select and write.
- `mem_addr`  out  ADDR_W  word byte address.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  one-cycle pulse; completes the current word.
- `mem_busy`  out  1  high in any GRANT state.

## Operation
- FSM states: IDLE, GRANT_I, GRANT_D. Extra state: `last_grant`, 1 bit (0=I, 1=D). Burst counter `cnt` of log2(WORDS) bits.
- IDLE transitions:
  - Only `d_req` high: go to GRANT_D.
  - Only `i_req` high: go to GRANT_I.
  - Both high: grant the requester not equal to `last_grant` (round-robin).
  - Neither high: stay in IDLE.
- Entering a GRANT state: `cnt`=0 and `last_grant` is updated to the winner.
- In a GRANT state:
  - `mem_cs`=1. `mem_we`=`d_we` in GRANT_D, else 0.
  - `mem_addr` = {line address with the low log2(WORDS)+2 bits cleared} | (`cnt`<<2).
  - `mem_wdata`=`d_wdata`. `word_idx`=`cnt`.
- On `mem_ack` in a GRANT state:
  - The winner's ack is driven high, and its rdata = `mem_rdata` (rdata is also driven on writes but has no meaning there).
  - If `cnt`≠WORDS-1: `cnt` increments.
  - Else: the winner's done is driven high and the FSM goes to IDLE.
- The loser's ack and done are 0 throughout. The loser's request stays pending and is served next.
- The requester drops req on the edge where it samples done. IDLE never sees the finished request again.
- `d_we` and the line addresses are sampled combinationally throughout the burst. The requester must hold them stable.
- Requests that drop mid-burst are ignored: the burst always completes WORDS words.
- `mem_addr` wraps modulo 2^ADDR_W. There is no boundary check.

## Timing
- Reset values: state=IDLE, `last_grant`=0 (D wins the first tie), `cnt`=0, and every output 0.
- `rst` mid-burst: immediate return to IDLE with `mem_cs`=0. The memory transaction is abandoned and no done is issued.
- A request is sampled at edge E. GRANT is entered at E, and `mem_cs`/`mem_addr` are valid in the cycle after E.
- Acks, rdata and done are combinational from `mem_ack`, in the same cycle.
- The next word's address appears the cycle after an ack.
- With a zero-wait memory (ack in the same cycle as cs): req seen in cycle 0, words in cycles 1..WORDS, done in cycle WORDS. IDLE returns in cycle WORDS+1, and a pending request is granted at the end of that cycle.
- Wait states are allowed: `mem_addr`, `mem_cs` and `mem_wdata` hold until `mem_ack`.
- `mem_busy` is registered state, with no combinational path from the requests.

## Test plan
- I refill: `i_addr`=0x1004, WORDS=4, zero-wait → `mem_addr` 0x1000, 0x1004, 0x1008, 0x100C in consecutive cycles; four `i_ack`; `i_done` with the fourth.
- D writeback: `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xA0+`word_idx` → `mem_we`=1, and memory receives 0xA0..0xA3 at 0x2000..0x200C. `d_done` on the last ack.
- Simultaneous: `i_req` and `d_req` high after reset → D burst first, then I. Repeat with both high again → D then I again, which checks that `last_grant` alternates the tie.
- Wait states: memory acks 3 cycles after each address → each address held 3 cycles; burst completes in 12 grant cycles. `mem_busy` high throughout.
- Reset mid-burst: assert `rst` after 2 of 4 acks → `mem_cs`=0 immediately, no done, IDLE after release. A fresh `i_req` restarts at word 0.
- Arrival during a burst: `i_req` rises while GRANT_D is in progress → no I ack until `d_done`. I is granted in the cycle following IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the main-memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int IDX_W = $clog2(WORDS);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic [IDX_W-1:0]  word_idx;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic              mem_busy;

  // Arbiter side.
  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_ack, i_rdata, i_done, d_ack, d_rdata, d_done,
           word_idx, mem_cs, mem_we, mem_addr, mem_wdata, mem_busy
  );

  // Requesters and memory side.
  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_ack, i_rdata, i_done, d_ack, d_rdata, d_done,
           word_idx, mem_cs, mem_we, mem_addr, mem_wdata, mem_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between I-refill and D-cache requesters for the single
// memory port; runs WORDS-word line bursts with per-word acks and a done pulse.
module mem_port_arbiter #(
  parameter int WORDS  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(WORDS);
  localparam int LOW_W = CNT_W + 2;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << LOW_W) - 64'd1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] line_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    line_addr    = '0;

    bus.i_ack     = 1'b0;
    bus.i_rdata   = '0;
    bus.i_done    = 1'b0;
    bus.d_ack     = 1'b0;
    bus.d_rdata   = '0;
    bus.d_done    = 1'b0;
    bus.word_idx  = '0;
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_busy  = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        // On a tie D wins unless D was the most recent winner.
        if (bus.d_req && (!bus.i_req || !last_grant_q)) begin
          state_d      = GRANT_D;
          last_grant_d = 1'b1;
          cnt_d        = '0;
        end else if (bus.i_req) begin
          state_d      = GRANT_I;
          last_grant_d = 1'b0;
          cnt_d        = '0;
        end
      end

      GRANT_I, GRANT_D: begin
        line_addr     = (state_q == GRANT_D) ? bus.d_addr : bus.i_addr;
        bus.mem_cs    = 1'b1;
        bus.mem_we    = (state_q == GRANT_D) && bus.d_we;
        bus.mem_addr  = (line_addr & ~LOW_MASK)
                      | {{(ADDR_W-LOW_W){1'b0}}, cnt_q, 2'b00};
        bus.mem_wdata = bus.d_wdata;
        bus.word_idx  = cnt_q;

        if (bus.mem_ack) begin
          if (state_q == GRANT_D) begin
            bus.d_ack   = 1'b1;
            bus.d_rdata = bus.mem_rdata;
          end else begin
            bus.i_ack   = 1'b1;
            bus.i_rdata = bus.mem_rdata;
          end

          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            bus.d_done = (state_q == GRANT_D);
            bus.i_done = (state_q == GRANT_I);
            state_d    = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: drives both requesters and a wait-state
// memory, logs every cycle, and checks the log against burst-level expectations.
module tb_mem_port_arbiter;
  localparam int WORDS  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk;
  logic rst;
  logic [DATA_W-1:0] d_wbase;

  mem_port_arbiter_if #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // D supplies the write word for whichever index is in flight.
  assign bus.d_wdata = d_wbase + DATA_W'(bus.word_idx);

  typedef struct {
    logic              cs, we, mack, ia, da, idn, ddn, busy;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, irdata, drdata;
    logic [1:0]        widx;
  } cyc_t;

  cyc_t        log_q[$];
  int unsigned n_cmp, n_err;
  int          mem_wait;
  int          age;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [DATA_W-1:0] rd_fn(input logic [ADDR_W-1:0] a);
    return a ^ 32'hC35A_0F0F;
  endfunction

  // One cycle: sample at negedge, then after the edge retire requests that
  // saw done and let the memory answer the (possibly new) address.
  task automatic step();
    cyc_t s;
    @(negedge clk);
    s.cs = bus.mem_cs;   s.we = bus.mem_we;     s.mack = bus.mem_ack;
    s.ia = bus.i_ack;    s.da = bus.d_ack;      s.idn = bus.i_done;
    s.ddn = bus.d_done;  s.busy = bus.mem_busy; s.addr = bus.mem_addr;
    s.wdata = bus.mem_wdata; s.irdata = bus.i_rdata; s.drdata = bus.d_rdata;
    s.widx = bus.word_idx;
    log_q.push_back(s);
    @(posedge clk);
    #1;
    if (s.idn) bus.i_req = 1'b0;
    if (s.ddn) bus.d_req = 1'b0;
    if (rst || !s.cs || s.mack) age = 0;
    else age++;
    bus.mem_ack   = bus.mem_cs && !rst && (age >= mem_wait);
    bus.mem_rdata = rd_fn(bus.mem_addr);
  endtask

  task automatic run_quiet(input int max);
    int n = 0;
    do begin
      step();
      n++;
    end while ((bus.mem_busy || bus.i_req || bus.d_req) && n < max);
    if (bus.mem_busy || bus.i_req || bus.d_req) begin
      n_cmp++; n_err++;
      $display("FAIL run_quiet: still active after %0d cycles (busy=%b ireq=%b dreq=%b), required idle",
               max, bus.mem_busy, bus.i_req, bus.d_req);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ack = 1'b0; age = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int bad = 0;
    #2;
    n_cmp++;
    if ({bus.i_ack, bus.i_done, bus.d_ack, bus.d_done, bus.mem_cs, bus.mem_we, bus.mem_busy} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {bus.i_ack, bus.i_done, bus.d_ack, bus.d_done, bus.mem_cs, bus.mem_we, bus.mem_busy});
    end
    n_cmp++;
    if ({bus.word_idx, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: idx=%0d addr=%h wdata=%h irdata=%h drdata=%h required all 0",
               bus.word_idx, bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    repeat (3) step();
    foreach (log_q[j]) if (log_q[j].cs !== 1'b0 || log_q[j].busy !== 1'b0) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_idle: %0d active cycles with no request, required 0", bad);
    end
  endtask

  task automatic test_i_refill();
    int f = -1;
    mem_wait = 0;
    log_q.delete();
    bus.i_addr = 32'h1004;
    bus.i_req  = 1'b1;
    run_quiet(50);
    foreach (log_q[j]) if (f < 0 && log_q[j].cs === 1'b1) f = j;
    n_cmp++;
    if (f != 1 || log_q.size() < 5) begin
      n_err++;
      $display("FAIL refill_latency: first cs at cycle %0d (log %0d), required 1", f, log_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        cyc_t e = log_q[f+k];
        logic [ADDR_W-1:0] ea = 32'h1000 + 4*k;
        n_cmp++;
        if (e.cs !== 1'b1 || e.addr !== ea || e.ia !== 1'b1 || e.da !== 1'b0 || e.we !== 1'b0 ||
            e.irdata !== rd_fn(ea) || e.idn !== (k == 3) || e.ddn !== 1'b0) begin
          n_err++;
          $display("FAIL refill_word%0d: cs=%b addr=%h ia=%b da=%b we=%b rd=%h done=%b, required cs=1 addr=%h ia=1 da=0 we=0 rd=%h done=%b",
                   k, e.cs, e.addr, e.ia, e.da, e.we, e.irdata, e.idn, ea, rd_fn(ea), k == 3);
        end
      end
    end
    n_cmp++;
    if (bus.mem_busy !== 1'b0 || bus.mem_cs !== 1'b0) begin
      n_err++;
      $display("FAIL refill_idle: busy=%b cs=%b after done, required 0 0", bus.mem_busy, bus.mem_cs);
    end
  endtask

  task automatic test_d_writeback();
    int n = 0;
    mem_wait = 0;
    log_q.delete();
    d_wbase    = 32'hA0;
    bus.d_we   = 1'b1;
    bus.d_addr = 32'h2000;
    bus.d_req  = 1'b1;
    run_quiet(50);
    foreach (log_q[j]) begin
      cyc_t e = log_q[j];
      if (e.cs && e.mack) begin
        n_cmp++;
        if (e.we !== 1'b1 || e.addr !== 32'h2000 + 4*n || e.wdata !== 32'hA0 + n || e.da !== 1'b1 ||
            e.ia !== 1'b0 || e.widx !== 2'(n) || e.ddn !== (n == 3)) begin
          n_err++;
          $display("FAIL wb_word%0d: we=%b addr=%h wdata=%h da=%b ia=%b idx=%0d done=%b, required we=1 addr=%h wdata=%h da=1 ia=0 idx=%0d done=%b",
                   n, e.we, e.addr, e.wdata, e.da, e.ia, e.widx, e.ddn, 32'h2000 + 4*n, 32'hA0 + n, n, n == 3);
        end
        n++;
      end
    end
    n_cmp++;
    if (n != 4) begin
      n_err++;
      $display("FAIL wb_count: %0d words written, required 4", n);
    end
    bus.d_we = 1'b0;
  endtask

  task automatic test_simultaneous();
    mem_wait = 0;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      logic [7:0] ord = '0;
      int n = 0, dd = -1, fi = -1;
      log_q.delete();
      bus.i_addr = 32'h1100 + 32'(r * 64);
      bus.d_addr = 32'h2200 + 32'(r * 64);
      bus.d_we   = 1'b0;
      bus.i_req  = 1'b1;
      bus.d_req  = 1'b1;
      run_quiet(60);
      foreach (log_q[j]) begin
        if (log_q[j].cs && log_q[j].mack) begin
          if (n < 8) ord[7-n] = log_q[j].da;
          n++;
        end
        if (dd < 0 && log_q[j].ddn) dd = j;
        if (fi < 0 && log_q[j].cs && log_q[j].ia) fi = j;
      end
      n_cmp++;
      if (n != 8 || ord !== 8'hF0) begin
        n_err++;
        $display("FAIL tie_order_r%0d: %0d words order %b, required 8 words order 11110000", r, n, ord);
      end
      n_cmp++;
      if (fi - dd != 2) begin
        n_err++;
        $display("FAIL tie_gap_r%0d: I first word at %0d, D done at %0d, required gap 2", r, fi, dd);
      end
    end
  endtask

  task automatic test_wait_states();
    int f = -1, ncs = 0;
    mem_wait = 2;
    log_q.delete();
    bus.i_addr = 32'h3000;
    bus.i_req  = 1'b1;
    run_quiet(100);
    foreach (log_q[j]) begin
      if (f < 0 && log_q[j].cs) f = j;
      if (log_q[j].cs) ncs++;
    end
    n_cmp++;
    if (ncs != 12 || f < 0 || f + 12 > log_q.size()) begin
      n_err++;
      $display("FAIL ws_len: %0d cs cycles (first %0d), required 12", ncs, f);
    end else begin
      for (int j = 0; j < 12; j++) begin
        cyc_t e = log_q[f+j];
        logic [ADDR_W-1:0] ea = 32'h3000 + 4*(j/3);
        n_cmp++;
        if (e.cs !== 1'b1 || e.busy !== 1'b1 || e.addr !== ea || e.ia !== (j % 3 == 2) || e.idn !== (j == 11)) begin
          n_err++;
          $display("FAIL ws_cycle%0d: cs=%b busy=%b addr=%h ack=%b done=%b, required cs=1 busy=1 addr=%h ack=%b done=%b",
                   j, e.cs, e.busy, e.addr, e.ia, e.idn, ea, j % 3 == 2, j == 11);
        end
      end
    end
    mem_wait = 0;
  endtask

  task automatic test_reset_mid_burst();
    int bad = 0, f = -1, ni = 0;
    mem_wait = 0;
    log_q.delete();
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h4000;
    bus.d_req  = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    bus.mem_ack = 1'b0;
    #1;
    n_cmp++;
    if ({bus.mem_cs, bus.mem_busy, bus.d_ack, bus.d_done} !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_mid_outputs: cs,busy,ack,done=%b, required 0000",
               {bus.mem_cs, bus.mem_busy, bus.d_ack, bus.d_done});
    end
    bus.d_req = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    log_q.delete();
    repeat (3) step();
    foreach (log_q[j]) if (log_q[j].cs || log_q[j].ddn || log_q[j].busy) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL rst_mid_idle: %0d active cycles after release, required 0", bad);
    end
    log_q.delete();
    bus.i_addr = 32'h5008;
    bus.i_req  = 1'b1;
    run_quiet(50);
    foreach (log_q[j]) begin
      if (f < 0 && log_q[j].cs) f = j;
      if (log_q[j].ia) ni++;
    end
    n_cmp++;
    if (f < 0 || log_q[f].addr !== 32'h5000 || log_q[f].widx !== 2'd0 || ni != 4) begin
      n_err++;
      $display("FAIL rst_mid_restart: first addr=%h idx=%0d acks=%0d, required 00005000 0 4",
               (f < 0) ? 32'hx : log_q[f].addr, (f < 0) ? 2'bx : log_q[f].widx, ni);
    end
  endtask

  task automatic test_arrival_during_burst();
    int dd = -1, fi = -1, early = 0, ni = 0, nd = 0;
    mem_wait = 1;
    log_q.delete();
    d_wbase    = 32'h600;
    bus.d_we   = 1'b1;
    bus.d_addr = 32'h6000;
    bus.d_req  = 1'b1;
    repeat (3) step();
    bus.i_addr = 32'h7000;
    bus.i_req  = 1'b1;
    run_quiet(100);
    foreach (log_q[j]) begin
      if (dd < 0 && log_q[j].ddn) dd = j;
      if (fi < 0 && log_q[j].cs && !log_q[j].we && log_q[j].addr === 32'h7000) fi = j;
      if (log_q[j].ia && dd < 0) early++;
      if (log_q[j].ia) ni++;
      if (log_q[j].da) nd++;
    end
    n_cmp++;
    if (early != 0 || ni != 4 || nd != 4) begin
      n_err++;
      $display("FAIL arrival_acks: early I acks=%0d I acks=%0d D acks=%0d, required 0 4 4", early, ni, nd);
    end
    n_cmp++;
    if (dd < 0 || fi - dd != 2) begin
      n_err++;
      $display("FAIL arrival_gap: I cs at %0d, D done at %0d, required gap 2", fi, dd);
    end
    bus.d_we = 1'b0;
    mem_wait = 0;
  endtask

  task automatic test_random();
    logic m_last_d = 1'b0;
    apply_reset();
    for (int it = 0; it < 20; it++) begin
      int sel = $urandom_range(1, 3);
      logic i_on = (sel & 1) != 0;
      logic d_on = (sel & 2) != 0;
      logic [ADDR_W-1:0] il = $urandom;
      logic [ADDR_W-1:0] dl = $urandom;
      logic dwe = 1'($urandom_range(0, 1));
      logic order[$];
      logic exp_who[$];
      logic [ADDR_W-1:0] exp_addr[$];
      int oi = 0, ncs = 0;
      mem_wait = $urandom_range(0, 2);
      d_wbase  = $urandom;
      if (i_on && d_on) order = m_last_d ? '{1'b0, 1'b1} : '{1'b1, 1'b0};
      else order = '{d_on};
      m_last_d = order[order.size()-1];
      foreach (order[b]) begin
        logic [ADDR_W-1:0] line = order[b] ? dl : il;
        logic [ADDR_W-1:0] base = line - (line % 32'd16);
        for (int k = 0; k < 4; k++) begin
          exp_who.push_back(order[b]);
          exp_addr.push_back(base + 32'(4*k));
        end
      end
      log_q.delete();
      bus.i_addr = il; bus.d_addr = dl; bus.d_we = dwe;
      bus.i_req = i_on; bus.d_req = d_on;
      run_quiet(200);
      foreach (log_q[j]) begin
        cyc_t e = log_q[j];
        if (e.cs) ncs++;
        if (e.cs && e.mack) begin
          if (oi < exp_who.size()) begin
            logic w = exp_who[oi];
            int k = oi % 4;
            logic [DATA_W-1:0] rd = w ? e.drdata : e.irdata;
            logic dn = w ? e.ddn : e.idn;
            n_cmp++;
            if (e.addr !== exp_addr[oi] || e.da !== w || e.ia !== !w || e.we !== (w && dwe) ||
                rd !== rd_fn(exp_addr[oi]) || dn !== (k == 3) || e.busy !== 1'b1 ||
                ((w && dwe) && e.wdata !== d_wbase + 32'(k))) begin
              n_err++;
              $display("FAIL rand_word it=%0d n=%0d: addr=%h da=%b ia=%b we=%b rd=%h done=%b wdata=%h, required addr=%h da=%b we=%b rd=%h done=%b wdata=%h",
                       it, oi, e.addr, e.da, e.ia, e.we, rd, dn, e.wdata,
                       exp_addr[oi], w, w && dwe, rd_fn(exp_addr[oi]), k == 3, d_wbase + 32'(k));
            end
          end
          oi++;
        end
      end
      n_cmp++;
      if (oi != exp_who.size() || ncs != exp_who.size() * (mem_wait + 1)) begin
        n_err++;
        $display("FAIL rand_count it=%0d: words=%0d cs_cycles=%0d, required %0d %0d",
                 it, oi, ncs, exp_who.size(), exp_who.size() * (mem_wait + 1));
      end
    end
    mem_wait = 0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; mem_wait = 0; age = 0;
    d_wbase = '0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    rst = 1'b1;
    test_reset();
    test_i_refill();
    test_d_writeback();
    test_simultaneous();
    test_wait_states();
    test_reset_mid_burst();
    test_arrival_during_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
